// File: rtl/lstm_seq_ctrl_if.sv
// lstm_seq_ctrl_if: handshake bundle between the sequence controller and one LSTM core step
// Signals: core_start (step request), core_x (x vector), core_y_in (recurrent h),
// core_finished (step complete), core_y_out (step result, valid while core_finished=1).
// Modports: master = controller side, slave = core side.
interface lstm_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    core_start;
    logic [4*DATA_WIDTH-1:0] core_x;
    logic [4*DATA_WIDTH-1:0] core_y_in;
    logic                    core_finished;
    logic [4*DATA_WIDTH-1:0] core_y_out;
    modport master (output core_start, core_x, core_y_in, input core_finished, core_y_out);
    modport slave (input core_start, core_x, core_y_in, output core_finished, core_y_out);
endinterface

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: runs an LSTM core over a buffered x sequence, feeding each result back as h
// Ports: clk; rst_n (async, active low); wr_en/wr_addr/wr_data load x slots while idle;
// seq_start/seq_len request a run; core is the master side of the core handshake;
// seq_busy, seq_done (pulse), seq_err (sticky), h_valid (pulse), step_idx, h_out report progress.
module lstm_seq_ctrl #(
    parameter int  DATA_WIDTH = 8,
    parameter int  MAX_LEN    = 5,
    parameter int  TIMEOUT    = 50,
    localparam int VW         = 4 * DATA_WIDTH,
    localparam int IW         = $clog2(MAX_LEN),
    localparam int LW         = $clog2(MAX_LEN + 1),
    localparam int CW         = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_addr,
    input  logic [VW-1:0]        wr_data,
    input  logic                 seq_start,
    input  logic [LW-1:0]        seq_len,
    lstm_seq_ctrl_if.master      core,
    output logic                 seq_busy,
    output logic                 seq_done,
    output logic                 seq_err,
    output logic                 h_valid,
    output logic [IW-1:0]        step_idx,
    output logic [VW-1:0]        h_out
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;
    state_t        state_q, state_d;
    logic          issue_q;
    logic [CW-1:0] wcnt_q;
    logic [IW-1:0] idx_q;
    logic [LW-1:0] len_q;
    logic [VW-1:0] h_q, h_out_q;
    logic          err_q;
    logic [VW-1:0] buf_q [MAX_LEN];
    logic          len_ok, timeout, last;
    assign len_ok  = seq_len != '0 && int'(seq_len) <= MAX_LEN;
    assign timeout = int'(wcnt_q) == TIMEOUT - 1;
    assign last    = int'(idx_q) + 1 == int'(len_q);
    // the buffer is frozen during a run so every step sees the x it was launched with
    always_ff @(posedge clk) begin
        if (wr_en && !seq_busy && int'(wr_addr) < MAX_LEN) buf_q[wr_addr] <= wr_data;
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = !seq_start ? IDLE : (len_ok ? ISSUE : DONE);
            ISSUE:   state_d = issue_q ? WAIT : ISSUE;
            WAIT:    state_d = core.core_finished ? CAPTURE : (timeout ? DONE : WAIT);
            CAPTURE: state_d = last ? DONE : ISSUE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            issue_q <= 1'b0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            h_q     <= '0;
            h_out_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= state_q == ISSUE && !issue_q;
            // zero outside WAIT, so the count restarts on every entry
            wcnt_q  <= state_q == WAIT ? wcnt_q + CW'(1) : '0;
            if (state_q == IDLE && seq_start) begin
                len_q <= seq_len;
                if (len_ok) begin
                    h_q   <= '0;
                    idx_q <= '0;
                    err_q <= 1'b0;
                end else if (seq_len != '0) begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == WAIT && core.core_finished) begin
                h_q     <= core.core_y_out;
                h_out_q <= core.core_y_out;
            end
            if (state_q == WAIT && !core.core_finished && timeout) err_q <= 1'b1;
            if (state_q == CAPTURE) idx_q <= idx_q + IW'(1);
        end
    end
    assign core.core_start = state_q == ISSUE;
    // idx reaches seq_len after the last step; keep the mux in range
    assign core.core_x     = int'(idx_q) < MAX_LEN ? buf_q[idx_q] : '0;
    assign core.core_y_in  = h_q;
    assign seq_busy        = state_q != IDLE;
    assign seq_done        = state_q == DONE;
    assign h_valid         = state_q == CAPTURE;
    assign seq_err         = err_q;
    assign step_idx        = idx_q;
    assign h_out           = h_out_q;
endmodule
